// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity-generating FIFO: the stored frame
// layout, the parity-sense constants and the parity function.
package parity_pkg;

    localparam int DATA_W  = 4;
    localparam int FRAME_W = DATA_W + 1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              par;
    } frame_t;

    // With odd sense the parity bit makes the total number of ones odd.
    function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_fifo_mem.sv
// DEPTH x frame register array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; the top masks reads with out_valid.
module parity_fifo_mem
    import parity_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  frame_t                   wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output frame_t                   rd_data
);

    frame_t mem_q [DEPTH];
    frame_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/parity_gen_fifo.sv
// FIFO that appends a parity bit to each pushed nibble and presents the head
// frame as individual a,b,c,d,p bits. Defining PARITY_ERR_INJ_EN adds an
// err_inj input that inverts the stored parity bit of the pushed nibble.
module parity_gen_fifo
    import parity_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ODD   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   a,
    output logic                   b,
    output logic                   c,
    output logic                   d,
    output logic                   p,
    output logic [$clog2(DEPTH):0] count
`ifdef PARITY_ERR_INJ_EN
    ,
    input  logic                   err_inj
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic PAR_SENSE = (ODD != 0) ? PAR_ODD : PAR_EVEN;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic   push;
    logic   pop;
    logic   inj;
    frame_t wr_frame;
    frame_t head;

    // in_ready looks only at count, so a full FIFO refuses a push even while popping.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

`ifdef PARITY_ERR_INJ_EN
    assign inj = err_inj;
`else
    assign inj = 1'b0;
`endif

    always_comb begin
        wr_frame.data = in_data;
        wr_frame.par  = calc_parity(in_data, PAR_SENSE) ^ inj;
    end

    // Pointers are exactly AW bits so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    parity_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (push),
        .wr_addr(wr_ptr_q),
        .wr_data(wr_frame),
        .rd_addr(rd_ptr_q),
        .rd_data(head)
    );

    // Masking by out_valid hides unreset storage and forces zeros under reset.
    assign {a, b, c, d} = head.data & {4{out_valid}};
    assign p            = head.par & out_valid;

endmodule

// File: tb/tb_parity_gen_fifo.sv
// Directed self-checking bench for parity_gen_fifo: an even-parity and an
// odd-parity instance, both DEPTH=4, driven with hand-computed vectors.
module tb_parity_gen_fifo;

   logic clk = 1'b0;
   logic rst;

   logic       e_in_valid, e_in_ready, e_out_valid, e_out_ready;
   logic [3:0] e_in_data;
   logic       e_a, e_b, e_c, e_d, e_p;
   logic [2:0] e_count;
   logic       e_err_inj;

   logic       o_in_valid, o_in_ready, o_out_valid, o_out_ready;
   logic [3:0] o_in_data;
   logic       o_a, o_b, o_c, o_d, o_p;
   logic [2:0] o_count;
   logic       o_err_inj;

   int vectors     = 0;
   int miscompares = 0;

   logic [3:0] stream_data [11];

   always #5 clk = ~clk;

   parity_gen_fifo #(.DEPTH(4), .ODD(0)) dut_even (
      .clk(clk), .rst(rst),
      .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data),
      .out_valid(e_out_valid), .out_ready(e_out_ready),
      .a(e_a), .b(e_b), .c(e_c), .d(e_d), .p(e_p),
      .count(e_count)
`ifdef PARITY_ERR_INJ_EN
      , .err_inj(e_err_inj)
`endif
   );

   parity_gen_fifo #(.DEPTH(4), .ODD(1)) dut_odd (
      .clk(clk), .rst(rst),
      .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data),
      .out_valid(o_out_valid), .out_ready(o_out_ready),
      .a(o_a), .b(o_b), .c(o_c), .d(o_d), .p(o_p),
      .count(o_count)
`ifdef PARITY_ERR_INJ_EN
      , .err_inj(o_err_inj)
`endif
   );

   // Advance one rising edge, then settle 1 time unit so outputs are stable.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] evenFrame();
      return {3'b000, e_a, e_b, e_c, e_d, e_p};
   endfunction

   function automatic logic [7:0] oddFrame();
      return {3'b000, o_a, o_b, o_c, o_d, o_p};
   endfunction

   initial begin
      rst = 1'b1;
      e_in_valid = 1'b0; e_in_data = 4'h0; e_out_ready = 1'b0; e_err_inj = 1'b0;
      o_in_valid = 1'b0; o_in_data = 4'h0; o_out_ready = 1'b0; o_err_inj = 1'b0;

      // Reset is asserted before any clock edge has occurred.
      #2;
      checkOutput("rst_count",     {5'b0, e_count},     8'd0);
      checkOutput("rst_in_ready",  {7'b0, e_in_ready},  8'd1);
      checkOutput("rst_out_valid", {7'b0, e_out_valid}, 8'd0);
      checkOutput("rst_frame",     evenFrame(),         8'h00);

      applyStimulus();
      rst = 1'b0;
      applyStimulus();

      // Even parity: 1011 has three ones, so p=1; visible only after the edge.
      e_in_valid = 1'b1; e_in_data = 4'b1011;
      checkOutput("no_fallthrough", {7'b0, e_out_valid}, 8'd0);
      applyStimulus();
      e_in_valid = 1'b0;
      checkOutput("even_1011_valid", {7'b0, e_out_valid}, 8'd1);
      checkOutput("even_1011_frame", evenFrame(),         8'b0001_0111);
      checkOutput("even_1011_count", {5'b0, e_count},     8'd1);
      e_out_ready = 1'b1;
      applyStimulus();
      e_out_ready = 1'b0;
      checkOutput("even_pop_count", {5'b0, e_count}, 8'd0);
      checkOutput("even_pop_frame", evenFrame(),     8'h00);

      // Odd parity: 0000 -> p=1, 0110 -> p=1.
      o_in_valid = 1'b1; o_in_data = 4'b0000;
      applyStimulus();
      o_in_data = 4'b0110;
      applyStimulus();
      o_in_valid = 1'b0;
      checkOutput("odd_count2",     {5'b0, o_count}, 8'd2);
      checkOutput("odd_0000_frame", oddFrame(),      8'b0000_0001);
      o_out_ready = 1'b1;
      applyStimulus();
      o_out_ready = 1'b0;
      checkOutput("odd_0110_frame", oddFrame(),      8'b0000_1101);

      // Offer 1..5 with out_ready low: only the first four fit.
      e_in_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         e_in_data = 4'(k);
         applyStimulus();
      end
      checkOutput("full_count",     {5'b0, e_count},    8'd4);
      checkOutput("full_in_ready",  {7'b0, e_in_ready}, 8'd0);
      checkOutput("full_head_1",    evenFrame(),        8'b0000_0011);

      // Full with both push and pop offered: pop happens, push is refused.
      e_out_ready = 1'b1;
      applyStimulus();
      e_out_ready = 1'b0;
      checkOutput("full_pop_count",    {5'b0, e_count},    8'd3);
      checkOutput("full_pop_in_ready", {7'b0, e_in_ready}, 8'd1);
      checkOutput("full_pop_head_2",   evenFrame(),        8'b0000_0101);
      applyStimulus();
      e_in_valid = 1'b0;
      checkOutput("retry_push_count", {5'b0, e_count}, 8'd4);

      // Drain: 2,3,4,5 with parities 1,0,1,0.
      e_out_ready = 1'b1;
      checkOutput("drain_2", evenFrame(), 8'b0000_0101);
      applyStimulus();
      checkOutput("drain_3", evenFrame(), 8'b0000_0110);
      applyStimulus();
      checkOutput("drain_4", evenFrame(), 8'b0000_1001);
      applyStimulus();
      checkOutput("drain_5", evenFrame(), 8'b0000_1010);
      applyStimulus();
      e_out_ready = 1'b0;
      checkOutput("drain_empty_count", {5'b0, e_count},     8'd0);
      checkOutput("drain_empty_valid", {7'b0, e_out_valid}, 8'd0);

      // Pop while empty must not move the pointers.
      e_out_ready = 1'b1;
      applyStimulus();
      e_out_ready = 1'b0;
      checkOutput("empty_pop_count", {5'b0, e_count}, 8'd0);

      // Streaming: prime one entry, then push and pop together for 10 cycles.
      for (int i = 0; i < 11; i++) stream_data[i] = 4'(i * 3 + 6);
      e_in_valid = 1'b1; e_in_data = stream_data[0];
      applyStimulus();
      e_out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         checkOutput($sformatf("stream_head_%0d", i - 1), evenFrame(),
                     {3'b000, stream_data[i-1], ^stream_data[i-1]});
         checkOutput($sformatf("stream_count_%0d", i - 1), {5'b0, e_count}, 8'd1);
         e_in_data = stream_data[i];
         applyStimulus();
      end
      e_in_valid = 1'b0; e_out_ready = 1'b0;
      checkOutput("stream_last_head", evenFrame(), {3'b000, stream_data[10], ^stream_data[10]});
      checkOutput("stream_last_count", {5'b0, e_count}, 8'd1);

`ifdef PARITY_ERR_INJ_EN
      // 1111 has even parity 0; injection stores p=1 and the checker flags it.
      e_out_ready = 1'b1;
      applyStimulus();
      e_out_ready = 1'b0;
      e_in_valid = 1'b1; e_in_data = 4'b1111; e_err_inj = 1'b1;
      applyStimulus();
      e_in_valid = 1'b0; e_err_inj = 1'b0;
      checkOutput("inj_frame", evenFrame(), 8'b0001_1111);
      checkOutput("inj_checker_e", {7'b0, e_out_valid & (^{e_a, e_b, e_c, e_d, e_p})}, 8'd1);
`endif

      // Asynchronous reset mid-stream, between clock edges.
      rst = 1'b1;
      #2;
      checkOutput("async_rst_count", {5'b0, e_count},     8'd0);
      checkOutput("async_rst_valid", {7'b0, e_out_valid}, 8'd0);
      checkOutput("async_rst_frame", evenFrame(),         8'h00);
      applyStimulus();
      rst = 1'b0;
      applyStimulus();

      // First push after reset lands in entry 0 and is the head; 1001 -> p=0.
      e_in_valid = 1'b1; e_in_data = 4'b1001;
      applyStimulus();
      e_in_data = 4'b0111;
      applyStimulus();
      e_in_valid = 1'b0;
      checkOutput("post_rst_head",  evenFrame(),     8'b0001_0010);
      checkOutput("post_rst_count", {5'b0, e_count}, 8'd2);
      e_out_ready = 1'b1;
      applyStimulus();
      e_out_ready = 1'b0;
      checkOutput("post_rst_second", evenFrame(), 8'b0000_1111);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/parity_gen_fifo.md
PARITY_GEN_FIFO -- requirements
Module: parity_gen_fifo

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter: ODD, 0, 0 = even parity, 1 = odd parity.
REQ-003 Reset: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_ready  output  1  block can accept a nibble.
REQ-008 in_data  input  4  data nibble {a,b,c,d}, MSB = a.
REQ-009 out_valid  output  1  a,b,c,d,p hold a valid frame.
REQ-010 out_ready  input  1  downstream parity checker consumes the frame.
REQ-011 a, b, c, d  output  1 each  data bits to the checker.
REQ-012 p  output  1  parity bit to the checker.
REQ-013 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 The push condition SHALL be in_valid && in_ready. The pop condition SHALL be out_valid && out_ready.
REQ-015 in_ready SHALL equal (count != DEPTH).
REQ-016 out_valid SHALL equal (count != 0).
REQ-017 On push, the block SHALL store {in_data, p} at the write pointer, where p = ^in_data XOR ODD.
REQ-018 a, b, c, d, p SHALL be driven from the head entry. They SHALL be 0 when the FIFO is empty.
REQ-019 Latency: a nibble pushed at edge N into an empty FIFO SHALL appear with out_valid=1 after edge N; there is no fall-through in the same cycle.
REQ-020 Ordering SHALL be strict FIFO.
REQ-021 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH without gaps.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and move both pointers.
REQ-023 When full, push SHALL be blocked even if a pop occurs in the same cycle, because in_ready depends only on count.
REQ-024 Pop when empty SHALL be a no-op. Push when full SHALL be a no-op. Neither may corrupt the pointers.
REQ-025 out_valid, once asserted, SHALL hold, and a..p SHALL hold stable, until a pop occurs.

Reset
REQ-026 Asserting rst SHALL force the pointers and count to 0, out_valid to 0, in_ready to 1, and a..p to 0, immediately and regardless of clk.
REQ-027 Reset mid-operation SHALL discard all stored entries. The first push after deassertion SHALL write entry 0.
REQ-028 Storage array contents need not be reset. The outputs SHALL be masked by out_valid.

Configuration
REQ-029 Macro: PARITY_ERR_INJ_EN.
REQ-030 When PARITY_ERR_INJ_EN is defined, the block SHALL add port err_inj (input, 1 bit). On a push with err_inj=1, the stored p SHALL be inverted. This gives the downstream checker a deliberate error.
REQ-031 When PARITY_ERR_INJ_EN is undefined, err_inj SHALL be absent and p SHALL always be correct per REQ-017.

Structure
REQ-032 Shared package parity_pkg SHALL hold the frame typedef (4-bit data plus parity bit), the EVEN/ODD constants, and the function that computes parity.
REQ-033 The design SHALL contain one sub-module, parity_fifo_mem: a DEPTH x 5 register array with a synchronous write port and an asynchronous read port. Pointer and count logic SHALL stay in the top level.

Verification
REQ-034 Reset with ODD=0, then push 4'b1011 -> one cycle later out_valid=1, {a,b,c,d}=1011, p=1.
REQ-035 ODD=1: push 4'b0000 -> p=1. Push 4'b0110 -> p=1.
REQ-036 DEPTH=4 with out_ready=0: push 5 nibbles 1..5 -> the first 4 are accepted, count=4, in_ready=0. Then pop all -> the order is 1,2,3,4.
REQ-037 Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> a pop occurs, no push occurs, count=3. The next cycle the push is accepted.
REQ-038 Push and pop every cycle for 10 cycles -> count stays at 1, pointers wrap twice, and no data is lost.
REQ-039 With PARITY_ERR_INJ_EN defined: push 4'b1111 with err_inj=1 -> p=1 under even parity, and the downstream checker's e asserts. Then assert rst mid-stream -> count=0 and out_valid=0 asynchronously.
